// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst encodings, master index width and
// the fixed-burst length helper used by the arbiter.
package ahb_pkg;

  localparam int unsigned AhbIdxW = 2;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HburstSingle = 3'b000,
    HburstIncr   = 3'b001,
    HburstWrap4  = 3'b010,
    HburstIncr4  = 3'b011,
    HburstWrap8  = 3'b100,
    HburstIncr8  = 3'b101,
    HburstWrap16 = 3'b110,
    HburstIncr16 = 3'b111
  } hburst_e;

  // Beats remaining after the NONSEQ beat; 0 for SINGLE and undefined-length INCR.
  function automatic logic [3:0] burst_beats_m1(logic [2:0] hburst);
    unique case (hburst)
      HburstWrap4,  HburstIncr4:  return 4'd3;
      HburstWrap8,  HburstIncr8:  return 4'd7;
      HburstWrap16, HburstIncr16: return 4'd15;
      default:                    return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational round-robin picker: first request after ptr_i (wrapping),
// or DefaultMaster when nothing is requested.
module ahb_arb_rr_pick
  import ahb_pkg::*;
#(
  parameter int unsigned NumMasters    = 4,
  parameter int unsigned DefaultMaster = 0
) (
  input  logic [NumMasters-1:0] req_i,
  input  logic [AhbIdxW-1:0]    ptr_i,
  output logic [AhbIdxW-1:0]    win_o,
  output logic [NumMasters-1:0] onehot_o
);

  logic found;

  always_comb begin
    found    = 1'b0;
    win_o    = AhbIdxW'(DefaultMaster);
    onehot_o = '0;
    // Offset k=1 is the master right after the pointer, k=NumMasters is the pointer itself.
    for (int unsigned k = 1; k <= NumMasters; k++) begin
      for (int unsigned j = 0; j < NumMasters; j++) begin
        if (!found && req_i[j] && (((32'(ptr_i) + k) % NumMasters) == j)) begin
          found = 1'b1;
          win_o = AhbIdxW'(j);
        end
      end
    end
    for (int unsigned j = 0; j < NumMasters; j++) begin
      onehot_o[j] = (32'(win_o) == j);
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with fixed-burst protection and default-master parking.
// Define AHB_ARB_LOCK_EN to let the owner's HLOCK hold the grant and drive HMASTLOCK.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [AhbIdxW-1:0]     HMASTER,
  output logic [AhbIdxW-1:0]     HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] GrantRst = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [AhbIdxW-1:0]     IdxRst   = AhbIdxW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q;
  // Index of the granted master; also serves as the round-robin pointer (last_owner).
  logic [AhbIdxW-1:0]     grant_idx_q;
  logic [AhbIdxW-1:0]     hmaster_q, hmaster_d_q;
  logic [3:0]             beats_q, beats_d;
  logic                   mastlock_q;
  logic                   owner_lock;
  logic                   hold;
  logic [AhbIdxW-1:0]     pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;

  ahb_arb_rr_pick #(
    .NumMasters   (NUM_MASTERS),
    .DefaultMaster(DEFAULT_MASTER)
  ) u_pick (
    .req_i   (HBUSREQ),
    .ptr_i   (grant_idx_q),
    .win_o   (pick_idx),
    .onehot_o(pick_onehot)
  );

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock = |(HLOCK & grant_q);
`else
  logic unused_hlock;
  assign unused_hlock = ^HLOCK;
  assign owner_lock   = 1'b0;
`endif

  always_comb begin
    beats_d = beats_q;
    if (HREADY) begin
      unique case (HTRANS)
        HtransNonseq: beats_d = burst_beats_m1(HBURST);
        HtransSeq:    beats_d = (beats_q != 4'd0) ? beats_q - 4'd1 : 4'd0;
        default:      ;
      endcase
    end
  end

  // The accept of the final SEQ leaves beats_d at 0, so the grant may move on that edge.
  assign hold = (beats_d != 4'd0) || owner_lock;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q     <= GrantRst;
      grant_idx_q <= IdxRst;
      hmaster_q   <= IdxRst;
      hmaster_d_q <= IdxRst;
      beats_q     <= 4'd0;
      mastlock_q  <= 1'b0;
    end else if (HREADY) begin
      beats_q     <= beats_d;
      hmaster_q   <= grant_idx_q;
      hmaster_d_q <= hmaster_q;
      mastlock_q  <= owner_lock;
      if (!hold) begin
        grant_q     <= pick_onehot;
        grant_idx_q <= pick_idx;
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = hmaster_d_q;
  assign HMASTLOCK = mastlock_q;

endmodule
